// File: rtl/overlay_pkg.sv
// overlay_pkg: shared types and constants for the overlay colour mapper.
//   rgb12_t      - packed {R,G,B} nibbles, same layout as the palette ROM word
//   fade_state_t - transition engine states
//   LEVEL_MAX    - full-brightness fade level (identity scale)
//   BG_*         - fixed per-screen background colours
//   fadeRgb()    - scales each channel by level/16, truncating
package overlay_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        FADE_IN
    } fade_state_t;

    localparam logic [4:0] LEVEL_MAX = 5'd16;

    localparam rgb12_t BG_SCR2  = 12'h060;
    localparam rgb12_t BG_SCR7  = 12'hF00;
    localparam rgb12_t BG_OTHER = 12'h007;

    // 4b x 5b fits in 9 bits; >>4 of at most 15*16 never exceeds 15.
    function automatic logic [3:0] fadeChan(input logic [3:0] c, input logic [4:0] level);
        logic [8:0] prod;
        prod = {5'd0, c} * {4'd0, level};
        return 4'(prod >> 4);
    endfunction

    function automatic rgb12_t fadeRgb(input rgb12_t c, input logic [4:0] level);
        rgb12_t o;
        o.r = fadeChan(c.r, level);
        o.g = fadeChan(c.g, level);
        o.b = fadeChan(c.b, level);
        return o;
    endfunction

endpackage

// File: rtl/circle_hit.sv
// circle_hit: one circular overlay test, two register stages.
//   S1: signed offsets dx/dy from the object centre, plus enable/radius/colour
//       so that every object attribute shares the pixel's latency.
//   S2: hit = enable & (dx^2 + dy^2 <= r^2), all in full 21-bit precision.
// Ports:
//   VGA_clk, Reset_n      clock / async active-low reset
//   drawX, drawY          current pixel coordinate
//   objX, objY, objR      object centre and radius
//   objEn, objColor       object enable and colour
//   hit, hitColor         S2 result and the colour to show on a hit
module circle_hit #(
    parameter int RW = 6
) (
    input  logic          VGA_clk,
    input  logic          Reset_n,
    input  logic [9:0]    drawX,
    input  logic [9:0]    drawY,
    input  logic [9:0]    objX,
    input  logic [9:0]    objY,
    input  logic [RW-1:0] objR,
    input  logic          objEn,
    input  logic [11:0]   objColor,
    output logic          hit,
    output logic [11:0]   hitColor
);

    logic signed [10:0] dx, dy;
    logic [RW-1:0]      rS1;
    logic               enS1;
    logic [11:0]        colS1;

    always_ff @(posedge VGA_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dx    <= '0;
            dy    <= '0;
            rS1   <= '0;
            enS1  <= 1'b0;
            colS1 <= '0;
        end else begin
            dx    <= $signed({1'b0, drawX}) - $signed({1'b0, objX});
            dy    <= $signed({1'b0, drawY}) - $signed({1'b0, objY});
            rS1   <= objR;
            enS1  <= objEn;
            colS1 <= objColor;
        end
    end

    // |dx| <= 1023 always fits in 10 bits, so squaring the magnitude is exact.
    logic [9:0]  absDx, absDy;
    logic [19:0] sqX, sqY;
    logic [20:0] distSq, radSq;

    always_comb begin
        absDx  = dx[10] ? 10'(-dx) : 10'(dx);
        absDy  = dy[10] ? 10'(-dy) : 10'(dy);
        sqX    = 20'(absDx) * 20'(absDx);
        sqY    = 20'(absDy) * 20'(absDy);
        distSq = {1'b0, sqX} + {1'b0, sqY};
        radSq  = 21'(rS1) * 21'(rS1);
    end

    always_ff @(posedge VGA_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit      <= 1'b0;
            hitColor <= '0;
        end else begin
            hit      <= enS1 && (distSq <= radSq);
            hitColor <= colS1;
        end
    end

endmodule

// File: rtl/overlay_color_mapper.sv
// overlay_color_mapper: composites NUM_OBJS circular overlays over a
// per-screen background and drives the VGA DAC with a registered RGB value.
// Screen changes go through a frame-counted fade-out / fade-in.
// Pipeline (3 cycles coordinate -> RGB):
//   S1 offsets + coordinate/blank registers, S2 hit flags + palette capture,
//   S3 colour select, fade scaling, blanking, output register.
// Ports:
//   VGA_clk, Reset_n         pixel clock / async active-low reset
//   blank                    1 = active video
//   DrawX, DrawY             pixel coordinate
//   currScreen               requested screen
//   obj_en/x/y/r/color       packed per-object attributes, object 0 wins
//   pal_rgb                  palette ROM word, one cycle behind DrawX/DrawY
//   Red, Green, Blue         registered pixel colour
//   fading                   1 while a transition is running
module overlay_color_mapper
    import overlay_pkg::*;
#(
    parameter int NUM_OBJS  = 4,
    parameter int RW        = 6,
    parameter int FADE_STEP = 2,
    parameter int FADE_EN   = 1
) (
    input  logic                   VGA_clk,
    input  logic                   Reset_n,
    input  logic                   blank,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic [2:0]             currScreen,
    input  logic [NUM_OBJS-1:0]    obj_en,
    input  logic [NUM_OBJS*10-1:0] obj_x,
    input  logic [NUM_OBJS*10-1:0] obj_y,
    input  logic [NUM_OBJS*RW-1:0] obj_r,
    input  logic [NUM_OBJS*12-1:0] obj_color,
    input  logic [11:0]            pal_rgb,
    output logic [3:0]             Red,
    output logic [3:0]             Green,
    output logic [3:0]             Blue,
    output logic                   fading
);

    localparam int FCNT_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;

    // ---------------- per-object hit tests (S1, S2) ----------------
    logic [NUM_OBJS-1:0]       hitS2;
    logic [NUM_OBJS-1:0][11:0] hitColS2;

    for (genvar i = 0; i < NUM_OBJS; i++) begin : gObj
        circle_hit #(.RW(RW)) uHit (
            .VGA_clk  (VGA_clk),
            .Reset_n  (Reset_n),
            .drawX    (DrawX),
            .drawY    (DrawY),
            .objX     (obj_x[10*i +: 10]),
            .objY     (obj_y[10*i +: 10]),
            .objR     (obj_r[RW*i +: RW]),
            .objEn    (obj_en[i]),
            .objColor (obj_color[12*i +: 12]),
            .hit      (hitS2[i]),
            .hitColor (hitColS2[i])
        );
    end

    // ---------------- coordinate / blank pipeline ----------------
    logic [2:1] vldPipe;   // blank after S1, after S2
    logic [9:0] drawXS1, drawYS1;
    logic [3:0] xNibS2;    // DrawX[6:3]: all that screen 0's ramp needs
    rgb12_t     palS2;

    always_ff @(posedge VGA_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vldPipe <= '0;
            drawXS1 <= '0;
            drawYS1 <= '0;
            xNibS2  <= '0;
            palS2   <= '0;
        end else begin
            vldPipe <= {vldPipe[1], blank};
            drawXS1 <= DrawX;
            drawYS1 <= DrawY;
            xNibS2  <= drawXS1[6:3];
            palS2   <= pal_rgb;   // ROM word belongs to the S1 coordinate
        end
    end

    logic frameTick;
    assign frameTick = (drawXS1 == 10'd0) && (drawYS1 == 10'd0);

    // ---------------- transition engine ----------------
    fade_state_t       state, stateNxt;
    logic [4:0]        level, levelNxt;
    logic [FCNT_W-1:0] fcnt, fcntNxt;
    logic [2:0]        shownScreen, shownNxt;
    logic              shownVld;  // shownScreen loaded after reset release
    logic              stepDue;

    assign stepDue = frameTick && (fcnt == FCNT_W'(FADE_STEP - 1));

    always_ff @(posedge VGA_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            level       <= LEVEL_MAX;
            fcnt        <= '0;
            shownScreen <= '0;
            shownVld    <= 1'b0;
        end else begin
            state       <= stateNxt;
            level       <= levelNxt;
            fcnt        <= fcntNxt;
            shownScreen <= shownNxt;
            shownVld    <= 1'b1;
        end
    end

    always_comb begin
        stateNxt = state;
        levelNxt = level;
        fcntNxt  = fcnt;
        shownNxt = shownScreen;
        if (!shownVld) begin
            // First edge after reset: adopt the requested screen, no fade.
            shownNxt = currScreen;
        end else if (FADE_EN == 0) begin
            if (frameTick) shownNxt = currScreen;
        end else begin
            unique case (state)
                IDLE: begin
                    if (currScreen != shownScreen) begin
                        stateNxt = FADE_OUT;
                        fcntNxt  = '0;
                    end
                end
                FADE_OUT: begin
                    // Target changes here are picked up when level hits 0.
                    if (frameTick) begin
                        if (stepDue) begin
                            fcntNxt  = '0;
                            levelNxt = level - 5'd1;
                            if (level == 5'd1) begin
                                shownNxt = currScreen;
                                stateNxt = FADE_IN;
                            end
                        end else begin
                            fcntNxt = fcnt + FCNT_W'(1);
                        end
                    end
                end
                FADE_IN: begin
                    if (currScreen != shownScreen) begin
                        // Reverse from the current level, no jump.
                        stateNxt = FADE_OUT;
                        fcntNxt  = '0;
                    end else if (frameTick) begin
                        if (stepDue) begin
                            fcntNxt  = '0;
                            levelNxt = level + 5'd1;
                            if (level == LEVEL_MAX - 5'd1) stateNxt = IDLE;
                        end else begin
                            fcntNxt = fcnt + FCNT_W'(1);
                        end
                    end
                end
                default: stateNxt = IDLE;
            endcase
        end
    end

    assign fading = (state != IDLE);

    // ---------------- S3: colour select, fade, output ----------------
    rgb12_t bgColor, pixColor;

    always_comb begin
        bgColor = BG_OTHER;
        case (shownScreen)
            3'd0:    bgColor = '{r: 4'd7 - xNibS2, g: 4'd0, b: 4'd0};
            3'd1:    bgColor = palS2;
            3'd2:    bgColor = BG_SCR2;
            3'd7:    bgColor = BG_SCR7;
            default: bgColor = BG_OTHER;
        endcase
        // Walk from the lowest priority up so object 0 is written last.
        pixColor = bgColor;
        for (int i = NUM_OBJS - 1; i >= 0; i--) begin
            if (hitS2[i]) pixColor = hitColS2[i];
        end
    end

    always_ff @(posedge VGA_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {Red, Green, Blue} <= '0;
        end else if (vldPipe[2]) begin
            {Red, Green, Blue} <= fadeRgb(pixColor, level);
        end else begin
            {Red, Green, Blue} <= '0;
        end
    end

endmodule

// File: doc/overlay_color_mapper.md
Name: overlay_color_mapper

Overview:
- Parametrised successor to the single-screen color mapper.
- Composites NUM_OBJS circular overlay objects (priority-ordered) over a per-screen background, with a pipelined, registered RGB output.
- Adds a frame-counted fade-out/fade-in transition engine triggered by screen changes.
- Sits between the VGA controller/palette ROM and the VGA DAC pins.

Parameters:
- NUM_OBJS, 4, number of circle overlays (1..8); index 0 has highest priority.
- RW, 6, radius width in bits.
- FADE_STEP, 2, frames per brightness step during a transition.
- FADE_EN, 1, 0 = screen switch takes effect at the next frame start, with no fade.

Ports:
- VGA_clk  in  1  pixel clock; all state is on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- blank  in  1  1 = active video (same polarity as the VGA controller).
- DrawX, DrawY  in  10 each  current pixel coordinate.
- currScreen  in  3  requested screen.
- obj_en  in  NUM_OBJS  per-object enable.
- obj_x, obj_y  in  NUM_OBJS*10 each  object centres, packed; object i at [10i+9:10i].
- obj_r  in  NUM_OBJS*RW  radii, packed.
- obj_color  in  NUM_OBJS*12  object colour {R,G,B}, packed.
- pal_rgb  in  12  palette ROM output; valid exactly 1 cycle after its DrawX/DrawY.
- Red, Green, Blue  out  4 each  registered pixel colour.
- fading  out  1  1 while a transition is in progress.

Behaviour:
- Reset (async, Reset_n=0):
  - Red/Green/Blue=0, fading=0, shown_screen=currScreen sampled at the reset release edge, level=16, state IDLE.
  - All pipeline stages cleared.
- Pipeline: latency is 3 cycles from DrawX/DrawY/blank to RGB.
  - S1: dx_i=DrawX-obj_x_i and dy_i=DrawY-obj_y_i (11-bit signed); register DrawX, DrawY, blank.
  - S2: hit_i = obj_en_i & (dx_i²+dy_i² <= r_i²), using 21-bit unsigned squares, no truncation. Capture pal_rgb here.
  - S3: select colour, apply fade, register outputs. blank is delayed alongside the data.
  - When the delayed blank=0, the output is 0.
- Colour select (S3), first match wins:
  - Lowest-index hit object: obj_color.
  - Otherwise, background by shown_screen:
    - 0: R = 7 - DrawX[9:3], truncated to 4 bits; G=B=0.
    - 1: pal_rgb.
    - 2: 0x060.
    - 7: 0xF00.
    - Other: 0x007.
- Fade arithmetic: each channel c_out = (c*level)>>4, with level in 0..16 (5-bit).
  - level=16 is identity.
  - Product width is 9 bits; no rounding.
- Frame tick: a one-cycle pulse when the S1 coordinates equal (0,0).
  - fcnt counts ticks 0..FADE_STEP-1; a step occurs on the tick where fcnt wraps.
- State machine, target = currScreen:
  - IDLE: if target != shown_screen, go to FADE_OUT, fading=1, fcnt=0.
  - FADE_OUT: level decrements by 1 per step.
    - On reaching 0, latch shown_screen=target and go to FADE_IN.
    - A target change here only updates the target; the fade continues.
  - FADE_IN: level increments by 1 per step.
    - On reaching 16, go to IDLE and set fading=0.
    - If target != shown_screen mid-fade-in, go to FADE_OUT from the current level.
  - FADE_EN=0: the FSM is bypassed. shown_screen updates on the next frame tick; level stays 16; fading stays 0.
- shown_screen and level change only on frame ticks, never mid-frame.
- Object inputs are sampled every cycle; changes mid-frame take effect after 3 cycles.
- Reset during a fade: immediate IDLE, level=16.

Decomposition:
- Package overlay_pkg: typedef rgb12_t (packed R,G,B nibbles); enum fade_state_t {IDLE, FADE_OUT, FADE_IN}; constants LEVEL_MAX=16 and the per-screen background colours.
- Sub-module circle_hit, instantiated NUM_OBJS times: registered dx/dy, then hit. It replaces the ad-hoc per-ball comparisons.

Test Plan:
- Reset, screen 2, no objects enabled, blank=1 -> after 3 cycles RGB=0x060; with blank=0 at the input, RGB=0 three cycles later.
- Objects 0 and 1 both at (320,240) with r=8, colours 0xF00 and 0x0F0 -> pixel (320,240) gives 0xF00; (328,240) gives 0xF00; (329,240) gives background; disabling obj0 gives 0x0F0.
- Circle boundary: obj at (0,0) with r=63 and DrawX=63, DrawY=0 -> hit. Negative dx (obj at 639, DrawX=600) -> hit iff 39² <= r².
- currScreen 2->7 with FADE_STEP=2 -> fading=1; level reaches 0 after 32 frame ticks; shown_screen=7; level 16 after 32 more ticks; fading=0. At level 8, pixel 0xF00 outputs 0x700.
- currScreen changes back to 2 at level 10 during FADE_IN -> FADE_OUT resumes from 10 with no jump; then fade-in shows screen 2.
- Reset_n asserted mid-fade -> outputs 0 immediately (asynchronous); after release, fading=0 and level=16. FADE_EN=0 build -> screen switches exactly at the next frame tick.
